// File: rtl/control_sequencer_if.sv
// Signal bundle between the microcode sequencer and the rest of the 8-bit CPU.
// The sequencer side uses the master modport; datapath blocks and benches use the slave modport.
interface control_sequencer_if #(
    parameter int CW_WIDTH = 15,
    parameter int OP_WIDTH = 4
);
    logic [OP_WIDTH-1:0] opcode;
    logic                cf;
    logic                zf;
    logic [CW_WIDTH-1:0] out;
    logic [2:0]          tstate;
    logic                halted;

    modport master (
        input  opcode,
        input  cf,
        input  zf,
        output out,
        output tstate,
        output halted
    );

    modport slave (
        output opcode,
        output cf,
        output zf,
        input  out,
        input  tstate,
        input  halted
    );
endinterface

// File: rtl/control_sequencer.sv
// Microcode sequencer: walks the T-state counter for fetch and execute and
// produces the 15-bit control word consumed by the PC/MAR/RAM/A/B/ALU/output blocks.
module control_sequencer (
    input logic                  clk,
    input logic                  clear,
    control_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        HALT = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } op_t;

    // Field order is the control-word bit map, bit 14 first.
    typedef struct packed {
        logic cp;
        logic ep;
        logic lp;
        logic n_lma;
        logic n_lmd;
        logic n_ce;
        logic n_lr;
        logic n_li;
        logic n_ei;
        logic n_la;
        logic ea;
        logic sub;
        logic eu;
        logic n_lb;
        logic n_lo;
    } cw_t;

    // All active-low strobes released, all active-high strobes off.
    localparam cw_t CW_IDLE = 15'h0FE3;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] op_q;
    cw_t        cw;

    // The IR value seen in T2 defines the whole instruction, so it is held for T3/T4.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= T0;
            op_q  <= OP_NOP;
        end else begin
            state <= state_nxt;
            if (state == T2) begin
                op_q <= bus.opcode;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through the
    // case statements can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cw        = CW_IDLE;

        case (state)
            T0: begin
                cw.ep     = 1'b1;
                cw.n_lma  = 1'b0;
                state_nxt = T1;
            end

            T1: begin
                cw.n_ce   = 1'b0;
                cw.n_li   = 1'b0;
                cw.cp     = 1'b1;
                state_nxt = T2;
            end

            T2: begin
                state_nxt = T0;
                case (bus.opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw.n_ei   = 1'b0;
                        cw.n_lma  = 1'b0;
                        state_nxt = T3;
                    end
                    OP_LDI: begin
                        cw.n_ei = 1'b0;
                        cw.n_la = 1'b0;
                    end
                    OP_JMP: begin
                        cw.n_ei = 1'b0;
                        cw.lp   = 1'b1;
                    end
                    OP_JC: begin
                        if (bus.cf) begin
                            cw.n_ei = 1'b0;
                            cw.lp   = 1'b1;
                        end
                    end
                    OP_JZ: begin
                        if (bus.zf) begin
                            cw.n_ei = 1'b0;
                            cw.lp   = 1'b1;
                        end
                    end
                    OP_OUT: begin
                        cw.ea   = 1'b1;
                        cw.n_lo = 1'b0;
                    end
                    OP_HLT: begin
                        state_nxt = HALT;
                    end
                    default: begin
                        // NOP and the unassigned opcodes 9-D: an idle T2 only.
                        state_nxt = T0;
                    end
                endcase
            end

            T3: begin
                state_nxt = T0;
                case (op_q)
                    OP_LDA: begin
                        cw.n_ce = 1'b0;
                        cw.n_la = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        cw.n_ce   = 1'b0;
                        cw.n_lb   = 1'b0;
                        state_nxt = T4;
                    end
                    OP_STA: begin
                        cw.ea     = 1'b1;
                        cw.n_lmd  = 1'b0;
                        state_nxt = T4;
                    end
                    default: begin
                        state_nxt = T0;
                    end
                endcase
            end

            T4: begin
                state_nxt = T0;
                case (op_q)
                    OP_ADD: begin
                        cw.eu   = 1'b1;
                        cw.n_la = 1'b0;
                    end
                    OP_SUB: begin
                        cw.eu   = 1'b1;
                        cw.sub  = 1'b1;
                        cw.n_la = 1'b0;
                    end
                    OP_STA: begin
                        cw.n_lr = 1'b0;
                    end
                    default: begin
                        state_nxt = T0;
                    end
                endcase
            end

            HALT: begin
                state_nxt = HALT;
            end

            default: begin
                state_nxt = T0;
            end
        endcase

        // Clear overrides the decoded word in the same cycle it is asserted.
        if (clear) begin
            cw        = CW_IDLE;
            state_nxt = T0;
        end
    end

    assign bus.out    = cw;
    assign bus.tstate = state;
    assign bus.halted = (state == HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: reset, every opcode's control-word sequence,
// flag/opcode sampling windows, and HALT behaviour.
module tb_control_sequencer;

    localparam logic [14:0] W_IDLE = 15'h0FE3;
    // T0 = Ep (bit 13) set with nLma (bit 11) pulled low.
    localparam logic [14:0] W_T0   = 15'h27E3;
    localparam logic [14:0] W_T1   = 15'h4D63;

    logic clk;
    logic clear;
    int   vectors;
    int   miscompares;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        c;
        logic        z;
        int          len;
        logic [14:0] w2;
        logic [14:0] w3;
        logic [14:0] w4;
    } vec_t;

    function automatic vec_t mk(string name, logic [3:0] op, logic c, logic z, int len,
                                logic [14:0] w2, logic [14:0] w3, logic [14:0] w4);
        vec_t v;
        v.name = name; v.op = op; v.c = c; v.z = z; v.len = len;
        v.w2 = w2; v.w3 = w3; v.w4 = w4;
        return v;
    endfunction

    // Inputs are changed 1 ns after the rising edge; outputs are read 1 ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        clear = 1'b1;
        next_cycle();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        restart();
        bus.opcode = 4'h2; bus.cf = 1'b0; bus.zf = 1'b0;
        next_cycle(); next_cycle(); next_cycle();
        #1;
        vectors++;
        if (bus.out !== 15'h0DE1 || bus.tstate !== 3'd3) begin
            miscompares++;
            $display("FAIL reset_pre_add_t3: out=%h tstate=%0d want out=0dE1 tstate=3", bus.out, bus.tstate);
        end
        clear = 1'b1;
        #1;
        vectors++;
        if (bus.out !== W_IDLE) begin
            miscompares++;
            $display("FAIL reset_clear_cycle1: out=%h want %h", bus.out, W_IDLE);
        end
        next_cycle();
        #1;
        vectors++;
        if (bus.out !== W_IDLE || bus.tstate !== 3'd0 || bus.halted !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_clear_cycle2: out=%h tstate=%0d halted=%b want %h/0/0",
                     bus.out, bus.tstate, bus.halted, W_IDLE);
        end
        next_cycle();
        clear = 1'b0;
        #1;
        vectors++;
        if (bus.out !== W_T0 || bus.tstate !== 3'd0 || bus.halted !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: out=%h tstate=%0d halted=%b want %h/0/0",
                     bus.out, bus.tstate, bus.halted, W_T0);
        end
        next_cycle();
    endtask

    // Instructions issued back to back; the next entry's T0 check also proves the previous length.
    task automatic test_back_to_back();
        vec_t        tbl [16];
        logic [14:0] want;
        tbl[0]  = mk("nop",    4'h0, 0, 0, 3, W_IDLE,   15'h0, 15'h0);
        tbl[1]  = mk("lda",    4'h1, 0, 0, 4, 15'h07A3, 15'h0DC3, 15'h0);
        tbl[2]  = mk("add",    4'h2, 0, 0, 5, 15'h07A3, 15'h0DE1, 15'h0FC7);
        tbl[3]  = mk("sub",    4'h3, 0, 0, 5, 15'h07A3, 15'h0DE1, 15'h0FCF);
        tbl[4]  = mk("sta",    4'h4, 0, 0, 5, 15'h07A3, 15'h0BF3, 15'h0EE3);
        tbl[5]  = mk("ldi",    4'h5, 0, 0, 3, 15'h0F83, 15'h0, 15'h0);
        tbl[6]  = mk("jmp",    4'h6, 0, 0, 3, 15'h1FA3, 15'h0, 15'h0);
        tbl[7]  = mk("jc_t",   4'h7, 1, 0, 3, 15'h1FA3, 15'h0, 15'h0);
        tbl[8]  = mk("jc_f",   4'h7, 0, 1, 3, W_IDLE,   15'h0, 15'h0);
        tbl[9]  = mk("jz_t",   4'h8, 0, 1, 3, 15'h1FA3, 15'h0, 15'h0);
        tbl[10] = mk("jz_f",   4'h8, 1, 0, 3, W_IDLE,   15'h0, 15'h0);
        tbl[11] = mk("out",    4'hE, 0, 0, 3, 15'h0FF2, 15'h0, 15'h0);
        tbl[12] = mk("op9",    4'h9, 1, 1, 3, W_IDLE,   15'h0, 15'h0);
        tbl[13] = mk("opA",    4'hA, 0, 0, 3, W_IDLE,   15'h0, 15'h0);
        tbl[14] = mk("opC",    4'hC, 1, 1, 3, W_IDLE,   15'h0, 15'h0);
        tbl[15] = mk("opD",    4'hD, 0, 0, 3, W_IDLE,   15'h0, 15'h0);
        restart();
        for (int k = 0; k < 16; k++) begin
            bus.opcode = tbl[k].op; bus.cf = tbl[k].c; bus.zf = tbl[k].z;
            for (int t = 0; t < tbl[k].len; t++) begin
                #1;
                case (t)
                    0:       want = W_T0;
                    1:       want = W_T1;
                    2:       want = tbl[k].w2;
                    3:       want = tbl[k].w3;
                    default: want = tbl[k].w4;
                endcase
                vectors++;
                if (bus.out !== want || bus.tstate !== 3'(t) || bus.halted !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s_t%0d: out=%h tstate=%0d halted=%b want %h/%0d/0",
                             tbl[k].name, t, bus.out, bus.tstate, bus.halted, want, t);
                end
                next_cycle();
            end
        end
        #1;
        vectors++;
        if (bus.tstate !== 3'd0 || bus.out !== W_T0) begin
            miscompares++;
            $display("FAIL b2b_end: out=%h tstate=%0d want %h/0", bus.out, bus.tstate, W_T0);
        end
    endtask

    task automatic test_sampling_windows();
        restart();
        // Flags differ in T0/T1; only the T2 value decides the jump.
        bus.opcode = 4'h7; bus.cf = 1'b1;
        next_cycle(); next_cycle();
        bus.cf = 1'b0;
        #1;
        vectors++;
        if (bus.out !== W_IDLE) begin
            miscompares++;
            $display("FAIL jc_late_clear: out=%h want %h", bus.out, W_IDLE);
        end
        next_cycle();
        bus.opcode = 4'h8; bus.zf = 1'b0;
        next_cycle(); next_cycle();
        bus.zf = 1'b1;
        #1;
        vectors++;
        if (bus.out !== 15'h1FA3) begin
            miscompares++;
            $display("FAIL jz_late_set: out=%h want 1fa3", bus.out);
        end
        next_cycle();
        // Flag toggles after T2 leave the fetch word untouched.
        bus.zf = 1'b0; bus.cf = 1'b1;
        #1;
        vectors++;
        if (bus.out !== W_T0) begin
            miscompares++;
            $display("FAIL flag_toggle_t0: out=%h want %h", bus.out, W_T0);
        end
        // HLT presented during fetch is ignored; JMP at T2 wins.
        bus.opcode = 4'hF;
        next_cycle(); next_cycle();
        bus.opcode = 4'h6;
        #1;
        vectors++;
        if (bus.out !== 15'h1FA3 || bus.halted !== 1'b0) begin
            miscompares++;
            $display("FAIL opcode_at_t2: out=%h halted=%b want 1fa3/0", bus.out, bus.halted);
        end
        next_cycle();
        // ADD latched at T2; the IR changing to LDA in T3 must not alter the sequence.
        bus.opcode = 4'h2;
        next_cycle(); next_cycle(); next_cycle();
        bus.opcode = 4'h1;
        #1;
        vectors++;
        if (bus.out !== 15'h0DE1) begin
            miscompares++;
            $display("FAIL add_t3_op_change: out=%h want 0de1", bus.out);
        end
        next_cycle();
        #1;
        vectors++;
        if (bus.out !== 15'h0FC7 || bus.tstate !== 3'd4) begin
            miscompares++;
            $display("FAIL add_t4_op_change: out=%h tstate=%0d want 0fc7/4", bus.out, bus.tstate);
        end
        next_cycle();
    endtask

    task automatic test_hlt();
        restart();
        bus.opcode = 4'hF; bus.cf = 1'b0; bus.zf = 1'b0;
        next_cycle(); next_cycle();
        #1;
        vectors++;
        if (bus.out !== W_IDLE || bus.halted !== 1'b0 || bus.tstate !== 3'd2) begin
            miscompares++;
            $display("FAIL hlt_t2: out=%h halted=%b tstate=%0d want %h/0/2",
                     bus.out, bus.halted, bus.tstate, W_IDLE);
        end
        next_cycle();
        for (int i = 0; i < 20; i++) begin
            bus.opcode = 4'($urandom_range(0, 15));
            bus.cf     = 1'($urandom_range(0, 1));
            bus.zf     = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if (bus.out !== W_IDLE || bus.halted !== 1'b1 || bus.tstate !== 3'd7) begin
                miscompares++;
                $display("FAIL halt_hold_%0d: out=%h halted=%b tstate=%0d want %h/1/7",
                         i, bus.out, bus.halted, bus.tstate, W_IDLE);
            end
            next_cycle();
        end
        clear = 1'b1;
        #1;
        vectors++;
        if (bus.out !== W_IDLE || bus.halted !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_clear_pending: out=%h halted=%b want %h/1", bus.out, bus.halted, W_IDLE);
        end
        next_cycle();
        clear = 1'b0;
        bus.opcode = 4'h0;
        #1;
        vectors++;
        if (bus.out !== W_T0 || bus.halted !== 1'b0 || bus.tstate !== 3'd0) begin
            miscompares++;
            $display("FAIL halt_exit: out=%h halted=%b tstate=%0d want %h/0/0",
                     bus.out, bus.halted, bus.tstate, W_T0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear       = 1'b1;
        bus.opcode  = 4'h0;
        bus.cf      = 1'b0;
        bus.zf      = 1'b0;
        next_cycle();
        test_reset();
        test_back_to_back();
        test_sampling_windows();
        test_hlt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
